// File: rtl/config_pkg.sv
// Shared types and constants for the SPI configuration loader.
// Frame geometry, FSM state encoding and the readback register mux.
package config_pkg;

    localparam int CFG_ADR_W      = 2;
    localparam int CFG_DAT_W      = 16;
    localparam int CFG_FRAME_BITS = 19;
    localparam int CFG_CMD_BITS   = 3;
    localparam int CFG_CNT_W      = 5;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_WAIT_CS
    } state_e;

    function automatic logic [CFG_DAT_W-1:0] reg_sel(
        input logic [CFG_ADR_W-1:0] adr,
        input logic [CFG_DAT_W-1:0] r0,
        input logic [CFG_DAT_W-1:0] r1,
        input logic [CFG_DAT_W-1:0] r2,
        input logic [CFG_DAT_W-1:0] r3
    );
        logic [CFG_DAT_W-1:0] v;
        unique case (adr)
            2'd0:    v = r0;
            2'd1:    v = r1;
            2'd2:    v = r2;
            default: v = r3;
        endcase
        return v;
    endfunction

    function automatic logic [CFG_CNT_W-1:0] cnt_inc(
        input logic [CFG_CNT_W-1:0] c
    );
        logic [CFG_CNT_W-1:0] v;
        if (c >= CFG_CNT_W'(CFG_FRAME_BITS))
            v = CFG_CNT_W'(CFG_FRAME_BITS);
        else
            v = c + 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/config_spi_loader_sync_edge.sv
// Multi-flop synchronizer with a previous-value register for edge detect.
// Flops reset low, so a pin already high at reset exit shows up as a rise.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/config_spi_loader.sv
// SPI slave front end: 19-bit frames become register write strobes,
// read frames stream the addressed register back on MISO.
module config_spi_loader
    import config_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 spi_csn_i,
    input  logic                 spi_sclk_i,
    input  logic                 spi_mosi_i,
    output logic                 spi_miso_o,
    input  logic [CFG_DAT_W-1:0] reg0_i,
    input  logic [CFG_DAT_W-1:0] reg1_i,
    input  logic [CFG_DAT_W-1:0] reg2_i,
    input  logic [CFG_DAT_W-1:0] reg3_i,
    output logic                 reg_wr_o,
    output logic [CFG_ADR_W-1:0] reg_adr_o,
    output logic [CFG_DAT_W-1:0] reg_dat_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    logic csn_lvl;
    logic csn_rise;
    logic csn_fall;
    logic sclk_rise;
    logic mosi;

    sync_edge #(.STAGES(SYNC_STAGES)) u_csn (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (spi_csn_i),
        .level_o (csn_lvl),
        .rise_o  (csn_rise),
        .fall_o  (csn_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (spi_sclk_i),
        .level_o (),
        .rise_o  (sclk_rise),
        .fall_o  ()
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (spi_mosi_i),
        .level_o (mosi),
        .rise_o  (),
        .fall_o  ()
    );

    state_e               state_q;
    logic [CFG_CNT_W-1:0] bit_cnt_q;
    logic [1:0]           cmd_sr_q;
    logic                 rw_q;
    logic [CFG_DAT_W-1:0] rx_sr_q;
    logic [CFG_DAT_W-1:0] tx_sr_q;
    logic                 ovf_q;
    logic                 reg_wr_q;
    logic [CFG_ADR_W-1:0] reg_adr_q;
    logic [CFG_DAT_W-1:0] reg_dat_q;
    logic                 frame_err_q;
    logic                 busy_q;

    logic                 in_frame;
    logic                 frame_ok;
    logic [CFG_ADR_W-1:0] cmd_adr;

    assign in_frame = (state_q == ST_CMD) || (state_q == ST_DATA) ||
                      (state_q == ST_WAIT_CS);
    assign frame_ok = (bit_cnt_q == CFG_CNT_W'(CFG_FRAME_BITS)) && !ovf_q;
    assign cmd_adr  = {cmd_sr_q[0], mosi};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_ARM;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            rw_q        <= 1'b0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            ovf_q       <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_adr_q   <= '0;
            reg_dat_q   <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            reg_wr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            if (in_frame && csn_rise) begin
                // Frame closed: commit, flag, or quietly finish a read.
                if (frame_ok && rw_q) begin
                    reg_wr_q  <= 1'b1;
                    reg_adr_q <= cmd_sr_q;
                    reg_dat_q <= rx_sr_q;
                end else if (!frame_ok) begin
                    frame_err_q <= 1'b1;
                end
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_ARM: begin
                        if (csn_lvl)
                            state_q <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (csn_fall) begin
                            state_q   <= ST_CMD;
                            bit_cnt_q <= '0;
                            ovf_q     <= 1'b0;
                            busy_q    <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            bit_cnt_q <= cnt_inc(bit_cnt_q);
                            cmd_sr_q  <= {cmd_sr_q[0], mosi};
                            if (bit_cnt_q == CFG_CNT_W'(CFG_CMD_BITS - 1)) begin
                                rw_q     <= cmd_sr_q[1];
                                cmd_sr_q <= cmd_adr;
                                tx_sr_q  <= reg_sel(cmd_adr, reg0_i, reg1_i,
                                                    reg2_i, reg3_i);
                                state_q  <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_rise) begin
                            bit_cnt_q <= cnt_inc(bit_cnt_q);
                            rx_sr_q   <= {rx_sr_q[CFG_DAT_W-2:0], mosi};
                            tx_sr_q   <= {tx_sr_q[CFG_DAT_W-2:0], 1'b0};
                            if (bit_cnt_q == CFG_CNT_W'(CFG_FRAME_BITS - 1))
                                state_q <= ST_WAIT_CS;
                        end
                    end
                    ST_WAIT_CS: begin
                        if (sclk_rise)
                            ovf_q <= 1'b1;
                    end
                    default: state_q <= ST_ARM;
                endcase
            end
        end
    end

    assign spi_miso_o  = ((state_q == ST_DATA) || (state_q == ST_WAIT_CS)) &&
                         !rw_q && tx_sr_q[CFG_DAT_W-1];
    assign reg_wr_o    = reg_wr_q;
    assign reg_adr_o   = reg_adr_q;
    assign reg_dat_o   = reg_dat_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = busy_q;

endmodule
